// File: rtl/ctrl_decode.sv
// RV32I decode front end: 2-entry instruction FIFO feeding a combinational decoder
// that produces the *_temp control bundle and counts illegal encodings.
module ctrl_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        PCSel_temp,
  output logic        RegWEn_temp,
  output logic        ASel_temp,
  output logic        BSel_temp,
  output logic        MemRW_temp,
  output logic [2:0]  DataRSel_temp,
  output logic [2:0]  ImmSel_temp,
  output logic [1:0]  DataWSel_temp,
  output logic [1:0]  WBSel_temp,
  output logic [3:0]  ALUSel_temp,
  output logic        illegal,
  output logic [7:0]  illegal_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  logic [31:0] mem_q [2];
  logic [31:0] mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [7:0]  illegal_cnt_q, illegal_cnt_d;

  logic        push, pop;
  logic [31:0] head;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        legal;

  logic        d_pcsel, d_regwen, d_asel, d_bsel, d_memrw;
  logic [2:0]  d_datarsel, d_immsel;
  logic [1:0]  d_datawsel, d_wbsel;
  logic [3:0]  d_alusel;

  // funct3 order maps onto ALUSel codes; alt selects sub/sra.
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_of = alt ? 4'd1 : 4'd0;
      3'd1:    alu_of = 4'd2;
      3'd2:    alu_of = 4'd3;
      3'd3:    alu_of = 4'd4;
      3'd4:    alu_of = 4'd5;
      3'd5:    alu_of = alt ? 4'd7 : 4'd6;
      3'd6:    alu_of = 4'd8;
      default: alu_of = 4'd9;
    endcase
  endfunction

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = inst_in;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (pop && illegal && (illegal_cnt_q != 8'hFF)) begin
      illegal_cnt_d = illegal_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0]      <= '0;
      mem_q[1]      <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      illegal_cnt_q <= 8'd0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign head   = mem_q[rd_ptr_q];
  assign opcode = head[6:0];
  assign funct3 = head[14:12];
  assign funct7 = head[31:25];

  // Raw per-opcode decode; legality and out_valid gating are applied afterwards.
  always_comb begin
    d_pcsel    = 1'b0;
    d_regwen   = 1'b0;
    d_asel     = 1'b0;
    d_bsel     = 1'b0;
    d_memrw    = 1'b0;
    d_datarsel = 3'd0;
    d_immsel   = 3'd0;
    d_datawsel = 2'd0;
    d_wbsel    = 2'd0;
    d_alusel   = 4'd0;
    legal      = 1'b0;
    case (opcode)
      OP_R: begin
        d_regwen = 1'b1;
        d_wbsel  = WB_ALU;
        d_alusel = alu_of(funct3, funct7[5]);
        legal    = (funct7 == 7'h00) ||
                   ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
      end
      OP_IALU: begin
        d_regwen = 1'b1;
        d_bsel   = 1'b1;
        d_immsel = IMM_I;
        d_wbsel  = WB_ALU;
        d_alusel = alu_of(funct3, (funct3 == 3'd5) && funct7[5]);
        if (funct3 == 3'd1)      legal = (funct7 == 7'h00);
        else if (funct3 == 3'd5) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        else                     legal = 1'b1;
      end
      OP_LOAD: begin
        d_regwen   = 1'b1;
        d_bsel     = 1'b1;
        d_immsel   = IMM_I;
        d_alusel   = ALU_ADD;
        d_wbsel    = WB_MEM;
        d_datarsel = funct3;
        legal      = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
      end
      OP_STORE: begin
        d_memrw    = 1'b1;
        d_bsel     = 1'b1;
        d_immsel   = IMM_S;
        d_alusel   = ALU_ADD;
        d_datawsel = funct3[1:0];
        legal      = (funct3 <= 3'd2);
      end
      OP_BRANCH: begin
        d_asel   = 1'b1;
        d_bsel   = 1'b1;
        d_immsel = IMM_B;
        d_alusel = ALU_ADD;
        legal    = (funct3 != 3'd2) && (funct3 != 3'd3);
      end
      OP_JAL: begin
        d_pcsel  = 1'b1;
        d_regwen = 1'b1;
        d_asel   = 1'b1;
        d_bsel   = 1'b1;
        d_immsel = IMM_J;
        d_alusel = ALU_ADD;
        d_wbsel  = WB_PC4;
        legal    = 1'b1;
      end
      OP_JALR: begin
        d_pcsel  = 1'b1;
        d_regwen = 1'b1;
        d_bsel   = 1'b1;
        d_immsel = IMM_I;
        d_alusel = ALU_ADD;
        d_wbsel  = WB_PC4;
        legal    = (funct3 == 3'd0);
      end
      OP_LUI: begin
        d_regwen = 1'b1;
        d_bsel   = 1'b1;
        d_immsel = IMM_U;
        d_alusel = ALU_PASSB;
        d_wbsel  = WB_ALU;
        legal    = 1'b1;
      end
      OP_AUIPC: begin
        d_regwen = 1'b1;
        d_asel   = 1'b1;
        d_bsel   = 1'b1;
        d_immsel = IMM_U;
        d_alusel = ALU_ADD;
        d_wbsel  = WB_ALU;
        legal    = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  logic emit;
  assign emit    = out_valid & legal;
  assign illegal = out_valid & ~legal;

  assign PCSel_temp    = emit & d_pcsel;
  assign RegWEn_temp   = emit & d_regwen;
  assign ASel_temp     = emit & d_asel;
  assign BSel_temp     = emit & d_bsel;
  assign MemRW_temp    = emit & d_memrw;
  assign DataRSel_temp = emit ? d_datarsel : 3'd0;
  assign ImmSel_temp   = emit ? d_immsel   : 3'd0;
  assign DataWSel_temp = emit ? d_datawsel : 2'd0;
  assign WBSel_temp    = emit ? d_wbsel    : 2'd0;
  assign ALUSel_temp   = emit ? d_alusel   : 4'd0;
  assign illegal_cnt   = illegal_cnt_q;

endmodule

// File: tb/tb_ctrl_decode.sv
// Bench for ctrl_decode: table of instruction/expected-bundle records pushed through
// the FIFO into a scoreboard queue, plus hand-written backpressure and reset sequences.
module tb_ctrl_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        PCSel_temp, RegWEn_temp, ASel_temp, BSel_temp, MemRW_temp;
  logic [2:0]  DataRSel_temp, ImmSel_temp;
  logic [1:0]  DataWSel_temp, WBSel_temp;
  logic [3:0]  ALUSel_temp;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  ctrl_decode dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .PCSel_temp(PCSel_temp), .RegWEn_temp(RegWEn_temp), .ASel_temp(ASel_temp),
    .BSel_temp(BSel_temp), .MemRW_temp(MemRW_temp), .DataRSel_temp(DataRSel_temp),
    .ImmSel_temp(ImmSel_temp), .DataWSel_temp(DataWSel_temp), .WBSel_temp(WBSel_temp),
    .ALUSel_temp(ALUSel_temp), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  // {pc, regwen, asel, bsel, memrw, datarsel[3], immsel[3], datawsel[2], wbsel[2], alusel[4], illegal}
  logic [19:0] act_b;
  assign act_b = {PCSel_temp, RegWEn_temp, ASel_temp, BSel_temp, MemRW_temp, DataRSel_temp,
                  ImmSel_temp, DataWSel_temp, WBSel_temp, ALUSel_temp, illegal};

  localparam logic [19:0] ILL = 20'h00001;

  typedef struct {
    logic [31:0] inst;
    logic [19:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [19:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          ill_model = 0;
  bit          rdy_run;

  function automatic logic [19:0] mk(input logic pc, input logic rw, input logic a, input logic b,
                                     input logic mem, input logic [2:0] dr, input logic [2:0] imm,
                                     input logic [1:0] dw, input logic [1:0] wb,
                                     input logic [3:0] alu, input logic ill);
    mk = {pc, rw, a, b, mem, dr, imm, dw, wb, alu, ill};
  endfunction

  task automatic add(input logic [31:0] inst, input logic [19:0] exp);
    vec_t v;
    v.inst = inst;
    v.exp  = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: compare the head on every pop; NOP bundle whenever the FIFO is empty.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {12'h0, act_b}, 32'hFFFFFFFF);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          check("decode_bundle", {12'h0, act_b}, {12'h0, e});
          if (e[0] && ill_model < 255) ill_model++;
        end
      end else if (!out_valid) begin
        check("empty_nop", {12'h0, act_b}, 32'h0);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_word(input logic [31:0] inst, input logic [19:0] exp);
    bit acc;
    acc      = 1'b0;
    inst_in  = inst;
    in_valid = 1'b1;
    for (int c = 0; c < 60 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) exp_q.push_back(exp);
    end
    #1;
    in_valid = 1'b0;
    if (!acc) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    ill_model = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [19:0] sw_exp, jal_exp, add_exp, lui_exp;
    add_exp = mk(0,1,0,0,0,3'd0,3'd0,2'd0,2'd1,4'd0,0);
    sw_exp  = mk(0,0,0,1,1,3'd0,3'd1,2'd2,2'd0,4'd0,0);
    jal_exp = mk(1,1,1,1,0,3'd0,3'd4,2'd0,2'd2,4'd0,0);
    lui_exp = mk(0,1,0,1,0,3'd0,3'd3,2'd0,2'd1,4'd10,0);

    add(32'h003100B3, add_exp);
    add(32'h403100B3, mk(0,1,0,0,0,3'd0,3'd0,2'd0,2'd1,4'd1,0));
    add(32'h003110B3, mk(0,1,0,0,0,3'd0,3'd0,2'd0,2'd1,4'd2,0));
    add(32'h003120B3, mk(0,1,0,0,0,3'd0,3'd0,2'd0,2'd1,4'd3,0));
    add(32'h003130B3, mk(0,1,0,0,0,3'd0,3'd0,2'd0,2'd1,4'd4,0));
    add(32'h003140B3, mk(0,1,0,0,0,3'd0,3'd0,2'd0,2'd1,4'd5,0));
    add(32'h003150B3, mk(0,1,0,0,0,3'd0,3'd0,2'd0,2'd1,4'd6,0));
    add(32'h403150B3, mk(0,1,0,0,0,3'd0,3'd0,2'd0,2'd1,4'd7,0));
    add(32'h003160B3, mk(0,1,0,0,0,3'd0,3'd0,2'd0,2'd1,4'd8,0));
    add(32'h003170B3, mk(0,1,0,0,0,3'd0,3'd0,2'd0,2'd1,4'd9,0));
    add(32'h403110B3, ILL);
    add(32'h023100B3, ILL);
    add(32'h00510093, mk(0,1,0,1,0,3'd0,3'd0,2'd0,2'd1,4'd0,0));
    add(32'hFFF10093, mk(0,1,0,1,0,3'd0,3'd0,2'd0,2'd1,4'd0,0));
    add(32'h00311093, mk(0,1,0,1,0,3'd0,3'd0,2'd0,2'd1,4'd2,0));
    add(32'h40311093, ILL);
    add(32'h40315093, mk(0,1,0,1,0,3'd0,3'd0,2'd0,2'd1,4'd7,0));
    add(32'h00517093, mk(0,1,0,1,0,3'd0,3'd0,2'd0,2'd1,4'd9,0));
    add(32'h00812083, mk(0,1,0,1,0,3'd2,3'd0,2'd0,2'd0,4'd0,0));
    add(32'h00814083, mk(0,1,0,1,0,3'd4,3'd0,2'd0,2'd0,4'd0,0));
    add(32'h00815083, mk(0,1,0,1,0,3'd5,3'd0,2'd0,2'd0,4'd0,0));
    add(32'h00813083, ILL);
    add(32'h00816083, ILL);
    add(32'h00512423, sw_exp);
    add(32'h00510423, mk(0,0,0,1,1,3'd0,3'd1,2'd0,2'd0,4'd0,0));
    add(32'h00511423, mk(0,0,0,1,1,3'd0,3'd1,2'd1,2'd0,4'd0,0));
    add(32'h00513423, ILL);
    add(32'h00208463, mk(0,0,1,1,0,3'd0,3'd2,2'd0,2'd0,4'd0,0));
    add(32'h0020F463, mk(0,0,1,1,0,3'd0,3'd2,2'd0,2'd0,4'd0,0));
    add(32'h0020A463, ILL);
    add(32'h0020B463, ILL);
    add(32'h008000EF, jal_exp);
    add(32'h000100E7, mk(1,1,0,1,0,3'd0,3'd0,2'd0,2'd2,4'd0,0));
    add(32'h000110E7, ILL);
    add(32'h000012B7, lui_exp);
    add(32'h00001297, mk(0,1,1,1,0,3'd0,3'd3,2'd0,2'd1,4'd0,0));
    add(32'hFFFFFFFF, ILL);
    add(32'h00000000, ILL);
    add(32'h003100B1, ILL);

    // Reset state
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_bundle", {12'h0, act_b}, 32'd0);
    check("rst_illegal_cnt", {24'd0, illegal_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single add: visible the cycle after the push edge, NOP the one after
    push_word(32'h003100B3, add_exp);
    @(negedge clk);
    check("lat_out_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("lat_then_empty", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    push_word(32'h00512423, sw_exp);
    push_word(32'h008000EF, jal_exp);
    drain();

    // Table pass 1: random idle gaps, consumer always ready
    foreach (tbl[i]) begin
      push_word(tbl[i].inst, tbl[i].exp);
      repeat ($urandom_range(0, 1)) @(posedge clk);
      #0;
    end
    drain();
    check("tbl_illegal_cnt", {24'd0, illegal_cnt}, ill_model);

    // Table pass 2: random consumer backpressure
    rdy_run = 1'b1;
    fork
      begin
        foreach (tbl[i]) push_word(tbl[i].inst, tbl[i].exp);
        rdy_run = 1'b0;
      end
      begin
        while (rdy_run) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 1) == 1);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("rand_illegal_cnt", {24'd0, illegal_cnt}, ill_model);

    // Full FIFO holds the third word until the consumer drains
    out_ready = 1'b0;
    push_word(32'h003100B3, add_exp);
    push_word(32'h00512423, sw_exp);
    fork
      push_word(32'h008000EF, jal_exp);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("full_in_ready", {31'd0, in_ready}, 32'd0);
          check("full_head_held", {12'h0, act_b}, {12'h0, add_exp});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Two illegal pops from reset
    do_reset();
    push_word(32'hFFFFFFFF, ILL);
    push_word(32'h403110B3, ILL);
    drain();
    check("illegal_cnt_two", {24'd0, illegal_cnt}, 32'd2);

    // Saturation
    for (int k = 0; k < 300; k++) begin
      w = $urandom;
      w[6:0] = 7'h7F;
      push_word(w, ILL);
    end
    drain();
    check("illegal_cnt_sat", {24'd0, illegal_cnt}, 32'd255);
    check("illegal_cnt_model", {24'd0, illegal_cnt}, ill_model);

    // Mid-cycle reset with a full FIFO
    out_ready = 1'b0;
    push_word(32'h00512423, sw_exp);
    push_word(32'h008000EF, jal_exp);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_bundle", {12'h0, act_b}, 32'd0);
    check("midrst_illegal_cnt", {24'd0, illegal_cnt}, 32'd0);
    exp_q.delete();
    ill_model = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    push_word(32'h000012B7, lui_exp);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL global_timeout: got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
